// File: rtl/memory_access.sv
// Memory stage of the 5-stage MIPS pipeline: forwards ALU results to writeback and runs
// LW/SW over a valid/data_ok data bus, holding upstream while an access is outstanding.
package memory_access_pkg;
  typedef struct packed {
    logic        mem_to_reg;
    logic        mem_write;
    logic        reg_write;
    logic        reg_dst;
    logic [31:0] alu_result;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
  } execute_data_t;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  execute_data_t ex_data,
  input  logic [31:0]   store_data,
  output logic          stall,
  output logic          dreq_valid,
  output logic [31:0]   dreq_addr,
  output logic [3:0]    dreq_strobe,
  output logic [31:0]   dreq_data,
  input  logic          dresp_data_ok,
  input  logic [31:0]   dresp_data,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [4:0]    wb_wa,
  output logic [31:0]   wb_data,
  output logic [31:0]   wb_pc,
  output logic          misalign,
  output logic          bus_error
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_q, load_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [STRB_W-1:0]   strobe_q, strobe_d;
  logic [RA_W-1:0]     wa_q, wa_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic                stall_q, stall_d;
  logic                dreq_valid_q, dreq_valid_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_reg_write_q, wb_reg_write_d;
  logic [RA_W-1:0]     wb_wa_q, wb_wa_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   wb_pc_q, wb_pc_d;
  logic                misalign_q, misalign_d;
  logic                bus_error_q, bus_error_d;

  logic                is_mem;
  logic                aligned;
  logic [RA_W-1:0]     ex_wa;

  assign is_mem  = ex_data.mem_to_reg | ex_data.mem_write;
  assign aligned = (ex_data.alu_result[1:0] == 2'b00);
  assign ex_wa   = ex_data.reg_dst ? ex_data.rd : ex_data.rt;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      load_q         <= 1'b0;
      addr_q         <= '0;
      sdata_q        <= '0;
      strobe_q       <= '0;
      wa_q           <= '0;
      pc_q           <= '0;
      stall_q        <= 1'b0;
      dreq_valid_q   <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_wa_q        <= '0;
      wb_data_q      <= '0;
      wb_pc_q        <= '0;
      misalign_q     <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      load_q         <= load_d;
      addr_q         <= addr_d;
      sdata_q        <= sdata_d;
      strobe_q       <= strobe_d;
      wa_q           <= wa_d;
      pc_q           <= pc_d;
      stall_q        <= stall_d;
      dreq_valid_q   <= dreq_valid_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_wa_q        <= wb_wa_d;
      wb_data_q      <= wb_data_d;
      wb_pc_q        <= wb_pc_d;
      misalign_q     <= misalign_d;
      bus_error_q    <= bus_error_d;
    end
  end

  // Next-state and writeback bundle
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_d         = load_q;
    addr_d         = addr_q;
    sdata_d        = sdata_q;
    strobe_d       = strobe_q;
    wa_d           = wa_q;
    pc_d           = pc_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_wa_d        = wb_wa_q;
    wb_data_d      = wb_data_q;
    wb_pc_d        = wb_pc_q;
    misalign_d     = 1'b0;
    bus_error_d    = bus_error_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_d   = ex_data.mem_to_reg;
          addr_d   = ex_data.alu_result;
          sdata_d  = store_data;
          strobe_d = ex_data.mem_write ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
          wa_d     = ex_wa;
          pc_d     = ex_data.pc;
          if (is_mem && aligned) begin
            state_d = ACCESS;
            cnt_d   = '0;
          end else begin
            // ALU op retires directly; a misaligned memory op retires without a write
            wb_valid_d     = 1'b1;
            wb_reg_write_d = ex_data.reg_write & ~is_mem;
            wb_wa_d        = ex_wa;
            wb_data_d      = ex_data.alu_result;
            wb_pc_d        = ex_data.pc;
            misalign_d     = is_mem;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dresp_data_ok) begin
          state_d        = IDLE;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = load_q;
          wb_wa_d        = wa_q;
          wb_data_d      = load_q ? dresp_data : addr_q;
          wb_pc_d        = pc_q;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d        = IDLE;
          bus_error_d    = 1'b1;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_wa_d        = wa_q;
          wb_data_d      = addr_q;
          wb_pc_d        = pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d      = (state_d == ACCESS);
    dreq_valid_d = (state_d == ACCESS);
  end

  assign stall        = stall_q;
  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = addr_q;
  assign dreq_strobe  = strobe_q;
  assign dreq_data    = sdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_wa        = wb_wa_q;
  assign wb_data      = wb_data_q;
  assign wb_pc        = wb_pc_q;
  assign misalign     = misalign_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU pass-through, LW/SW handshakes, misalign,
// timeout boundary, sticky bus error and asynchronous reset mid-access.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  execute_data_t ex_data;
  logic [31:0]   store_data;
  logic          stall;
  logic          dreq_valid;
  logic [31:0]   dreq_addr;
  logic [3:0]    dreq_strobe;
  logic [31:0]   dreq_data;
  logic          dresp_data_ok;
  logic [31:0]   dresp_data;
  logic          wb_valid;
  logic          wb_reg_write;
  logic [4:0]    wb_wa;
  logic [31:0]   wb_data;
  logic [31:0]   wb_pc;
  logic          misalign;
  logic          bus_error;

  int checks   = 0;
  int failures = 0;

  memory_access #(.TIMEOUT_CYCLES(255)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .ex_data       (ex_data),
    .store_data    (store_data),
    .stall         (stall),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_wa         (wb_wa),
    .wb_data       (wb_data),
    .wb_pc         (wb_pc),
    .misalign      (misalign),
    .bus_error     (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic execute_data_t mk(input logic m2r, input logic mw, input logic rw,
                                       input logic rdst, input logic [31:0] alu,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [31:0] pc);
    execute_data_t e;
    e.mem_to_reg = m2r;
    e.mem_write  = mw;
    e.reg_write  = rw;
    e.reg_dst    = rdst;
    e.alu_result = alu;
    e.rt         = rt;
    e.rd         = rd;
    e.pc         = pc;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn        = 1'b0;
    in_valid      = 1'b0;
    ex_data       = '0;
    store_data    = '0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    repeat (3) step();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_strobe", 32'(dreq_strobe), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // addi rt=3 <- 5
    in_valid = 1'b1;
    ex_data  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 5'd3, 5'd7, 32'h40);
    step();
    in_valid = 1'b0;
    check("addi_wb_valid", 32'(wb_valid), 32'd1);
    check("addi_wa", 32'(wb_wa), 32'd3);
    check("addi_data", wb_data, 32'd5);
    check("addi_rw", 32'(wb_reg_write), 32'd1);
    check("addi_pc", wb_pc, 32'h40);
    check("addi_dreq", 32'(dreq_valid), 32'd0);
    check("addi_stall", 32'(stall), 32'd0);
    step();
    check("bubble_wb_valid", 32'(wb_valid), 32'd0);

    // R-type writing r0 via rd
    in_valid = 1'b1;
    ex_data  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'd9, 5'd4, 5'd0, 32'h44);
    step();
    in_valid = 1'b0;
    check("r0_wb_valid", 32'(wb_valid), 32'd1);
    check("r0_wa", 32'(wb_wa), 32'd0);
    check("r0_data", wb_data, 32'd9);
    check("r0_dreq", 32'(dreq_valid), 32'd0);

    // lw 0x100, data_ok in third ACCESS cycle
    in_valid = 1'b1;
    ex_data  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 5'd8, 5'd1, 32'h48);
    step();
    in_valid = 1'b0;
    check("lw_c1_dreq", 32'(dreq_valid), 32'd1);
    check("lw_c1_stall", 32'(stall), 32'd1);
    check("lw_addr", dreq_addr, 32'h100);
    check("lw_strobe", 32'(dreq_strobe), 32'd0);
    check("lw_c1_wb_valid", 32'(wb_valid), 32'd0);
    step();
    check("lw_c2_dreq", 32'(dreq_valid), 32'd1);
    in_valid = 1'b1;
    ex_data  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 5'd20, 5'd21, 32'h99);
    step();
    in_valid = 1'b0;
    check("lw_c3_stall", 32'(stall), 32'd1);
    check("lw_c3_addr", dreq_addr, 32'h100);
    check("lw_ignore_in", 32'(wb_valid), 32'd0);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hDEADBEEF;
    step();
    check("lw_wb_valid", 32'(wb_valid), 32'd1);
    check("lw_wb_data", wb_data, 32'hDEADBEEF);
    check("lw_wb_rw", 32'(wb_reg_write), 32'd1);
    check("lw_wb_wa", 32'(wb_wa), 32'd8);
    check("lw_wb_pc", wb_pc, 32'h48);
    check("lw_done_stall", 32'(stall), 32'd0);
    check("lw_done_dreq", 32'(dreq_valid), 32'd0);
    step();
    check("stray_ok_wb_valid", 32'(wb_valid), 32'd0);
    check("stray_ok_stall", 32'(stall), 32'd0);
    dresp_data_ok = 1'b0;

    // sw 0x104, immediate data_ok
    in_valid   = 1'b1;
    ex_data    = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 5'd5, 5'd0, 32'h4C);
    store_data = 32'h1234;
    step();
    in_valid = 1'b0;
    check("sw_strobe", 32'(dreq_strobe), 32'hF);
    check("sw_data", dreq_data, 32'h1234);
    check("sw_addr", dreq_addr, 32'h104);
    check("sw_dreq", 32'(dreq_valid), 32'd1);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h5555AAAA;
    step();
    dresp_data_ok = 1'b0;
    check("sw_wb_valid", 32'(wb_valid), 32'd1);
    check("sw_wb_rw", 32'(wb_reg_write), 32'd0);
    check("sw_stall", 32'(stall), 32'd0);

    // misaligned lw 0x102
    in_valid = 1'b1;
    ex_data  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h102, 5'd6, 5'd0, 32'h50);
    step();
    in_valid = 1'b0;
    check("mis_wb_valid", 32'(wb_valid), 32'd1);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_rw", 32'(wb_reg_write), 32'd0);
    check("mis_dreq", 32'(dreq_valid), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    step();
    check("mis_pulse_end", 32'(misalign), 32'd0);

    // data_ok in the last ACCESS cycle before timeout wins
    in_valid = 1'b1;
    ex_data  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h180, 5'd10, 5'd0, 32'h54);
    step();
    in_valid = 1'b0;
    repeat (254) step();
    check("edge_still_access", 32'(stall), 32'd1);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hCAFEF00D;
    step();
    dresp_data_ok = 1'b0;
    check("edge_wb_valid", 32'(wb_valid), 32'd1);
    check("edge_wb_data", wb_data, 32'hCAFEF00D);
    check("edge_wb_rw", 32'(wb_reg_write), 32'd1);
    check("edge_no_bus_err", 32'(bus_error), 32'd0);

    // timeout after 255 ACCESS cycles
    in_valid = 1'b1;
    ex_data  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 5'd9, 5'd0, 32'h58);
    step();
    in_valid = 1'b0;
    n = 0;
    while (stall === 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("to_access_cycles", 32'(n), 32'd255);
    check("to_bus_error", 32'(bus_error), 32'd1);
    check("to_wb_valid", 32'(wb_valid), 32'd1);
    check("to_wb_rw", 32'(wb_reg_write), 32'd0);
    check("to_wb_wa", 32'(wb_wa), 32'd9);
    check("to_dreq", 32'(dreq_valid), 32'd0);
    step();
    check("to_sticky", 32'(bus_error), 32'd1);
    check("to_wb_pulse_end", 32'(wb_valid), 32'd0);

    // async reset during ACCESS
    in_valid = 1'b1;
    ex_data  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 5'd11, 5'd0, 32'h5C);
    step();
    in_valid = 1'b0;
    check("ar_pre_dreq", 32'(dreq_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("ar_dreq", 32'(dreq_valid), 32'd0);
    check("ar_stall", 32'(stall), 32'd0);
    check("ar_wb_valid", 32'(wb_valid), 32'd0);
    check("ar_bus_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    in_valid = 1'b1;
    ex_data  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd42, 5'd12, 5'd0, 32'h60);
    step();
    in_valid = 1'b0;
    check("post_wb_valid", 32'(wb_valid), 32'd1);
    check("post_wb_data", wb_data, 32'd42);
    check("post_wb_wa", 32'(wb_wa), 32'd12);
    check("post_dreq", 32'(dreq_valid), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
